// File: rtl/scratch_stack_unit.sv
// Data stack: TOS in a register, deeper entries in synchronous-read RAM. PUSH/DUP/REPLACE/short POP take 1 cycle.
// A POP from depth>=2 drops cmd_ready for 2 cycles while the new TOS is fetched from RAM.
module scratch_stack_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] tos,
  output logic [AW:0]      depth,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clear
);

  typedef enum logic [1:0] {IDLE, POP_RD, POP_LD} state_t;

  localparam logic [1:0]  OP_DUP  = 2'b00;
  localparam logic [1:0]  OP_PUSH = 2'b01;
  localparam logic [1:0]  OP_POP  = 2'b10;
  localparam logic [1:0]  OP_REPL = 2'b11;
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] FULL_D  = (AW+1)'(DEPTH);

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_dat;
  logic [WIDTH-1:0] push_dat;
  logic [AW:0]      depth_m1;
  logic [AW-1:0]    ram_addr;
  logic             accept;
  logic             is_grow;
  logic             ovf;
  logic             unf;
  logic             ram_we;

  assign cmd_ready = (state == IDLE);
  assign empty     = (depth == '0);
  assign full      = (depth == FULL_D);
  assign accept    = cmd_valid && cmd_ready;
  assign is_grow   = (cmd_op == OP_PUSH) || (cmd_op == OP_DUP);
  assign ovf       = accept && is_grow && full;
  assign unf       = accept && empty && (cmd_op != OP_PUSH);
  assign push_dat  = (cmd_op == OP_DUP) ? tos : cmd_data;
  assign ram_we    = accept && is_grow && !ovf && !unf && !empty;

  // Same address serves the spill write (old depth-1) and, in POP_RD,
  // the refill read (depth already decremented, so old depth-2).
  assign depth_m1  = depth - ONE;
  assign ram_addr  = depth_m1[AW-1:0];

  always_ff @(posedge CLK) begin
    if (ram_we)
      mem[ram_addr] <= tos;
    if (state == POP_RD)
      rd_dat <= mem[ram_addr];
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      tos     <= '0;
      depth   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      // Set wins over a coincident clear.
      if (ovf)            err_ovf <= 1'b1;
      else if (err_clear) err_ovf <= 1'b0;
      if (unf)            err_unf <= 1'b1;
      else if (err_clear) err_unf <= 1'b0;

      case (state)
        IDLE: begin
          if (accept && !ovf && !unf) begin
            case (cmd_op)
              OP_DUP, OP_PUSH: begin
                tos   <= push_dat;
                depth <= depth + ONE;
              end
              OP_REPL: tos <= cmd_data;
              OP_POP: begin
                depth <= depth_m1;
                if (depth == ONE) tos <= '0;
                else              state <= POP_RD;
              end
              default: ;
            endcase
          end
        end
        POP_RD: state <= POP_LD;
        POP_LD: begin
          tos   <= rd_dat;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratch_stack_unit.sv
// Directed and model-checked stimulus for scratch_stack_unit (DEPTH=8).
module tb_scratch_stack_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] DUP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;

  logic             CLK = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] tos;
  logic [AW:0]      depth;
  logic             empty, full, err_ovf, err_unf;
  logic             err_clear = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ovf, m_unf;

  scratch_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .tos(tos), .depth(depth),
    .empty(empty), .full(full), .err_ovf(err_ovf), .err_unf(err_unf),
    .err_clear(err_clear)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge, hold it while the unit is busy, return #1 after the accept edge.
  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] dat, input logic clr);
    int n;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = dat; err_clear = clr;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_wait", {63'd0, cmd_ready}, 64'd1);
    @(posedge CLK); #1;
    cmd_valid = 1'b0; err_clear = 1'b0;
  endtask

  task automatic pop_chk(input logic [WIDTH-1:0] old_tos, input logic [WIDTH-1:0] new_tos,
                         input int new_depth);
    do_op(POP, '0, 1'b0);
    chk("pop_ready_n", {63'd0, cmd_ready}, 64'd0);
    chk("pop_depth_n", 64'(depth), 64'(new_depth));
    chk("pop_tos_hold", 64'(tos), 64'(old_tos));
    @(posedge CLK); #1;
    chk("pop_ready_n1", {63'd0, cmd_ready}, 64'd0);
    chk("pop_tos_n1", 64'(tos), 64'(old_tos));
    @(posedge CLK); #1;
    chk("pop_ready_n2", {63'd0, cmd_ready}, 64'd1);
    chk("pop_tos_n2", 64'(tos), 64'(new_tos));
  endtask

  task automatic clear_pulse();
    @(negedge CLK); err_clear = 1'b1;
    @(posedge CLK); #1; err_clear = 1'b0;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [WIDTH-1:0] dat, input logic clr);
    logic so, su;
    so = 1'b0; su = 1'b0;
    case (op)
      PUSH: if (q.size() == DEPTH) so = 1'b1; else q.push_back(dat);
      DUP:  if (q.size() == 0) su = 1'b1;
            else if (q.size() == DEPTH) so = 1'b1;
            else q.push_back(q[q.size()-1]);
      POP:  if (q.size() == 0) su = 1'b1; else void'(q.pop_back());
      default: if (q.size() == 0) su = 1'b1; else q[q.size()-1] = dat;
    endcase
    m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = su ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  task automatic model_chk();
    logic [WIDTH-1:0] mt;
    mt = (q.size() == 0) ? '0 : q[q.size()-1];
    chk("rnd_tos", 64'(tos), 64'(mt));
    chk("rnd_depth", 64'(depth), 64'(q.size()));
    chk("rnd_empty", {63'd0, empty}, 64'(q.size() == 0));
    chk("rnd_full", {63'd0, full}, 64'(q.size() == DEPTH));
    chk("rnd_ovf", {63'd0, err_ovf}, {63'd0, m_ovf});
    chk("rnd_unf", {63'd0, err_unf}, {63'd0, m_unf});
  endtask

  initial begin
    logic [1:0]       rop;
    logic [WIDTH-1:0] rdat;
    logic             rclr;
    int               n;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_tos", 64'(tos), 64'd0);
    chk("rst_depth", 64'(depth), 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_errs", {62'd0, err_ovf, err_unf}, 64'd0);
    @(negedge CLK); resetn = 1'b1;

    // 1: PUSH/DUP single cycle, POP multi-cycle
    do_op(PUSH, 32'd5, 1'b0);
    chk("t1_ready_push", {63'd0, cmd_ready}, 64'd1);
    chk("t1_tos_push5", 64'(tos), 64'd5);
    do_op(PUSH, 32'd7, 1'b0);
    chk("t1_ready_push7", {63'd0, cmd_ready}, 64'd1);
    do_op(DUP, 32'hDEAD, 1'b0);
    chk("t1_ready_dup", {63'd0, cmd_ready}, 64'd1);
    chk("t1_tos_dup", 64'(tos), 64'd7);
    chk("t1_depth_dup", 64'(depth), 64'd3);
    pop_chk(32'd7, 32'd7, 2);
    pop_chk(32'd7, 32'd5, 1);
    do_op(POP, '0, 1'b0);
    chk("t1_last_pop_ready", {63'd0, cmd_ready}, 64'd1);
    chk("t1_last_pop_tos", 64'(tos), 64'd0);
    chk("t1_last_pop_empty", {63'd0, empty}, 64'd1);

    // 2: fill, overflow, drain
    for (int i = 1; i <= DEPTH; i++) do_op(PUSH, WIDTH'(i), 1'b0);
    chk("t2_full", {63'd0, full}, 64'd1);
    chk("t2_depth_full", 64'(depth), 64'd8);
    do_op(PUSH, 32'd9, 1'b0);
    chk("t2_ovf", {63'd0, err_ovf}, 64'd1);
    chk("t2_ovf_tos", 64'(tos), 64'd8);
    chk("t2_ovf_depth", 64'(depth), 64'd8);
    do_op(DUP, '0, 1'b0);
    chk("t2_dup_full_depth", 64'(depth), 64'd8);
    chk("t2_dup_full_unf", {63'd0, err_unf}, 64'd0);
    clear_pulse();
    chk("t2_ovf_clr", {63'd0, err_ovf}, 64'd0);
    for (int i = DEPTH; i >= 2; i--) pop_chk(WIDTH'(i), WIDTH'(i - 1), i - 1);
    do_op(POP, '0, 1'b0);
    chk("t2_pop1_tos", 64'(tos), 64'd0);
    chk("t2_pop1_empty", {63'd0, empty}, 64'd1);
    chk("t2_pop1_ready", {63'd0, cmd_ready}, 64'd1);

    // 3: underflow and clear priority
    do_op(POP, '0, 1'b0);
    chk("t3_unf_pop", {63'd0, err_unf}, 64'd1);
    do_op(DUP, '0, 1'b0);
    do_op(REPL, 32'd3, 1'b0);
    chk("t3_unf", {63'd0, err_unf}, 64'd1);
    chk("t3_depth", 64'(depth), 64'd0);
    chk("t3_tos", 64'(tos), 64'd0);
    chk("t3_ovf", {63'd0, err_ovf}, 64'd0);
    clear_pulse();
    chk("t3_clr", {63'd0, err_unf}, 64'd0);
    do_op(POP, '0, 1'b1);
    chk("t3_set_wins", {63'd0, err_unf}, 64'd1);
    clear_pulse();

    // 4: REPLACE leaves RAM alone
    do_op(PUSH, 32'hA, 1'b0);
    do_op(PUSH, 32'hB, 1'b0);
    do_op(REPL, 32'hC, 1'b0);
    chk("t4_repl_tos", 64'(tos), 64'hC);
    chk("t4_repl_depth", 64'(depth), 64'd2);
    pop_chk(32'hC, 32'hA, 1);
    chk("t4_ram0", 64'(u_dut.mem[0]), 64'hA);
    do_op(POP, '0, 1'b0);

    // 5: reset in the middle of a POP
    do_op(PUSH, 32'd1, 1'b0);
    do_op(PUSH, 32'd2, 1'b0);
    do_op(POP, '0, 1'b0);
    chk("t5_busy", {63'd0, cmd_ready}, 64'd0);
    resetn = 1'b0;
    #1;
    chk("t5_rst_tos", 64'(tos), 64'd0);
    chk("t5_rst_depth", 64'(depth), 64'd0);
    chk("t5_rst_ready", {63'd0, cmd_ready}, 64'd1);
    @(negedge CLK); resetn = 1'b1;
    do_op(PUSH, 32'd6, 1'b0);
    chk("t5_push_tos", 64'(tos), 64'd6);
    chk("t5_push_depth", 64'(depth), 64'd1);
    do_op(POP, '0, 1'b0);

    // 6: random stream against a queue model
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      rop  = 2'($urandom_range(3));
      rdat = $urandom;
      rclr = ($urandom_range(15) == 0);
      do_op(rop, rdat, rclr);
      model_op(rop, rdat, rclr);
      if ($urandom_range(1) == 1) begin
        n = 0;
        while (!cmd_ready && n < 5) begin
          @(posedge CLK); #1;
          n++;
        end
      end
      if (cmd_ready) model_chk();
    end
    n = 0;
    while (!cmd_ready && n < 5) begin
      @(posedge CLK); #1;
      n++;
    end
    model_chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
